// File: rtl/or_serial_unit.sv
// ---------------------------------------------------------------------------
// or_serial_unit
//   Bit-serial OR engine. Two WIDTH-bit operands are accepted over a
//   valid/ready input port. They are ORed one bit per clock through a single
//   1-bit OR stage, least significant bit first. The finished word is
//   presented on a valid/ready output port.
//
//   Flow:   IDLE --accept--> SHIFT (WIDTH cycles) --> DONE --taken--> IDLE
//
//   Optional feature (compile-time macro OR_SERIAL_ZERO_FLAG_EN):
//     adds the registered output outZero. It is 1 when the finished result
//     is all zeros. It is loaded on the same edge as out and is valid while
//     outValid is high. When the macro is undefined, the port and its logic
//     do not exist.
//
//   All outputs are registered. Their next values are derived from the
//   next FSM state, so each output changes on the same edge as the state.
// ---------------------------------------------------------------------------
module or_serial_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] out,
    output logic             busy
`ifdef OR_SERIAL_ZERO_FLAG_EN
    ,
    output logic             outZero
`endif
);

    // Counter must be able to hold WIDTH itself; the last SHIFT edge
    // increments the count from WIDTH-1 to WIDTH.
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam int               MSB_POS  = WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] reg_a_q,  reg_a_d;
    logic [WIDTH-1:0] reg_b_q,  reg_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] out_q,    out_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;
`ifdef OR_SERIAL_ZERO_FLAG_EN
    logic             zero_q,      zero_d;
`endif

    // The single 1-bit OR stage: it works on the current LSBs of the
    // captured operands.
    logic             or_bit_s;
    logic [WIDTH-1:0] shift_res_s;

    // The new OR bit enters at the MSB and older bits move toward the LSB.
    // The result is built with a shift plus an OR rather than a slice, so
    // WIDTH=1 needs no special case.
    always_comb begin
        or_bit_s    = reg_a_q[0] | reg_b_q[0];
        shift_res_s = (result_q >> 1'b1) | (WIDTH'(or_bit_s) << MSB_POS);
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d  = state_q;
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        result_d = result_q;
        count_d  = count_q;
        out_d    = out_q;
`ifdef OR_SERIAL_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Accept only when inReady is already high. This keeps the
                // first edge after reset release from taking operands.
                if (inValid && in_ready_q) begin
                    reg_a_d  = inA;
                    reg_b_d  = inB;
                    count_d  = CNT_ZERO;
                    result_d = {WIDTH{1'b0}};
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                result_d = shift_res_s;
                reg_a_d  = reg_a_q >> 1'b1;
                reg_b_d  = reg_b_q >> 1'b1;
                count_d  = count_q + CNT_ONE;
                if (count_q == CNT_LAST) begin
                    // Final bit: publish the finished word on this edge.
                    state_d = ST_DONE;
                    out_d   = shift_res_s;
`ifdef OR_SERIAL_ZERO_FLAG_EN
                    zero_d  = (shift_res_s == {WIDTH{1'b0}});
`endif
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // Hold the result until the consumer takes it. New operands
                // are only considered after the return to IDLE.
                if (outReady) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs follow the state the FSM is entering.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            ST_IDLE:  in_ready_d  = 1'b1;
            ST_SHIFT: busy_d      = 1'b1;
            ST_DONE:  out_valid_d = 1'b1;
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers. Reset aborts any operation.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            reg_a_q     <= {WIDTH{1'b0}};
            reg_b_q     <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            count_q     <= CNT_ZERO;
            out_q       <= {WIDTH{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_a_q     <= reg_a_d;
            reg_b_q     <= reg_b_d;
            result_q    <= result_d;
            count_q     <= count_d;
            out_q       <= out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef OR_SERIAL_ZERO_FLAG_EN
    // All-zero result flag. It is loaded together with out.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign outZero = zero_q;
`endif

    assign inReady  = in_ready_q;
    assign outValid = out_valid_q;
    assign out      = out_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_or_serial_unit.sv
// ---------------------------------------------------------------------------
// tb_or_serial_unit
//   Directed bench for or_serial_unit with WIDTH=8. Inputs are driven and
//   outputs are sampled 1 time unit after each rising edge. Expected values
//   are hand-computed constants. When OR_SERIAL_ZERO_FLAG_EN is defined,
//   outZero is also checked.
// ---------------------------------------------------------------------------
module tb_or_serial_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         resetN;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] out;
    logic         busy;
`ifdef OR_SERIAL_ZERO_FLAG_EN
    logic         outZero;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    or_serial_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .inValid  (inValid),
        .inReady  (inReady),
        .inA      (inA),
        .inB      (inB),
        .outValid (outValid),
        .outReady (outReady),
        .out      (out),
        .busy     (busy)
`ifdef OR_SERIAL_ZERO_FLAG_EN
        ,
        .outZero  (outZero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present operands for one edge; the unit must be in IDLE with inReady=1.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        inA     = a;
        inB     = b;
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        check_value({tag, "_busy"}, 32'(busy), 32'd1);
        check_value({tag, "_inrdy"}, 32'(inReady), 32'd0);
    endtask

    // Wait for the result. Check the accept-to-valid latency, the number of
    // busy cycles and the result value.
    task automatic wait_result(input logic [W-1:0] exp, input string tag, input bit churn);
        int lat;
        int bcnt;
        lat  = 0;
        bcnt = (busy === 1'b1) ? 1 : 0;
        while (outValid !== 1'b1 && lat < 20) begin
            if (churn) begin
                inA     = 8'($urandom);
                inB     = 8'($urandom);
                inValid = 1'($urandom_range(0, 1));
            end
            step();
            lat++;
            if (busy === 1'b1) bcnt++;
        end
        inValid = 1'b0;
        check_value({tag, "_lat"}, 32'(lat), 32'd8);
        check_value({tag, "_busycnt"}, 32'(bcnt), 32'd8);
        check_value({tag, "_out"}, 32'(out), 32'(exp));
`ifdef OR_SERIAL_ZERO_FLAG_EN
        check_value({tag, "_zero"}, 32'(outZero), (exp == 8'h00) ? 32'd1 : 32'd0);
`endif
    endtask

    // Let the consumer take the result; the unit must be back in IDLE.
    task automatic handoff(input string tag);
        outReady = 1'b1;
        step();
        check_value({tag, "_ho_vld"}, 32'(outValid), 32'd0);
        check_value({tag, "_ho_rdy"}, 32'(inReady), 32'd1);
    endtask

    logic [W-1:0] va [3] = '{8'hAA, 8'hC3, 8'h34};
    logic [W-1:0] vb [3] = '{8'h55, 8'hF0, 8'h76};
    logic [W-1:0] ve [3] = '{8'hFF, 8'hF3, 8'h76};

    logic [W-1:0] ba [4] = '{8'h5A, 8'h0F, 8'h12, 8'h80};
    logic [W-1:0] bb [4] = '{8'h81, 8'hF0, 8'h34, 8'h01};
    logic [W-1:0] be [4] = '{8'hDB, 8'hFF, 8'h36, 8'h81};

    initial begin
        int acc [4];
        int n;

        resetN   = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        inA      = 8'h00;
        inB      = 8'h00;
        repeat (2) step();

        // Reset values, then inReady rises on the first edge after release.
        check_value("rst_vld", 32'(outValid), 32'd0);
        check_value("rst_out", 32'(out), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_rdy", 32'(inReady), 32'd0);
        resetN = 1'b1;
        check_value("rel_rdy0", 32'(inReady), 32'd0);
        step();
        check_value("rel_rdy1", 32'(inReady), 32'd1);

        // In IDLE, outReady alone has no effect.
        outReady = 1'b1;
        step();
        check_value("idle_ordy_vld", 32'(outValid), 32'd0);
        check_value("idle_ordy_rdy", 32'(inReady), 32'd1);

        // All-zero operands.
        accept(8'h00, 8'h00, "zero");
        wait_result(8'h00, "zero", 1'b0);
        handoff("zero");

        // Directed patterns.
        for (int i = 0; i < 3; i++) begin
            accept(va[i], vb[i], $sformatf("vec%0d", i));
            wait_result(ve[i], $sformatf("vec%0d", i), 1'b0);
            handoff($sformatf("vec%0d", i));
        end

        // Backpressure: hold the result 5 cycles while new operands are offered.
        outReady = 1'b0;
        accept(8'h0F, 8'h30, "bp");
        wait_result(8'h3F, "bp", 1'b0);
        for (int i = 0; i < 5; i++) begin
            inValid = 1'b1;
            inA     = 8'hFF;
            inB     = 8'hFF;
            step();
            check_value($sformatf("bp_hold%0d_vld", i), 32'(outValid), 32'd1);
            check_value($sformatf("bp_hold%0d_out", i), 32'(out), 32'h3F);
            check_value($sformatf("bp_hold%0d_rdy", i), 32'(inReady), 32'd0);
        end
        outReady = 1'b1;
        step();
        check_value("bp_rel_vld", 32'(outValid), 32'd0);
        check_value("bp_rel_rdy", 32'(inReady), 32'd1);
        check_value("bp_rel_busy", 32'(busy), 32'd0);
        step();
        inValid = 1'b0;
        check_value("bp_next_busy", 32'(busy), 32'd1);
        wait_result(8'hFF, "bp_next", 1'b0);
        handoff("bp_next");

        // Operand churn during SHIFT must not disturb the captured operands.
        accept(8'h21, 8'h04, "churn");
        wait_result(8'h25, "churn", 1'b1);
        handoff("churn");

        // Back-to-back traffic with inValid and outReady held high.
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inA     = ba[i];
            inB     = bb[i];
            inValid = 1'b1;
            n = 0;
            while (busy !== 1'b1 && n < 30) begin
                step();
                n++;
            end
            acc[i] = cyc;
            if (i > 0) begin
                check_value($sformatf("b2b%0d_gap", i), 32'(acc[i] - acc[i-1]), 32'd10);
            end
            n = 0;
            while (outValid !== 1'b1 && n < 30) begin
                step();
                n++;
            end
            check_value($sformatf("b2b%0d_lat", i), 32'(n), 32'd8);
            check_value($sformatf("b2b%0d_out", i), 32'(out), 32'(be[i]));
        end
        inValid = 1'b0;
        step();
        check_value("b2b_idle_rdy", 32'(inReady), 32'd1);

        // Reset in the middle of SHIFT aborts the operation and clears out.
        accept(8'h0F, 8'h00, "abort");
        repeat (3) step();
        resetN = 1'b0;
        #1;
        check_value("abort_vld", 32'(outValid), 32'd0);
        check_value("abort_out", 32'(out), 32'd0);
        check_value("abort_busy", 32'(busy), 32'd0);
        check_value("abort_rdy", 32'(inReady), 32'd0);
        step();
        resetN = 1'b1;
        check_value("abort_rel_rdy0", 32'(inReady), 32'd0);
        step();
        check_value("abort_rel_rdy1", 32'(inReady), 32'd1);
        accept(8'h01, 8'h02, "recover");
        wait_result(8'h03, "recover", 1'b0);
        handoff("recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
